// File: rtl/branch_feedback_gen_pkg.sv
// Shared hart definitions and common parameters for the branch feedback path.
package branch_feedback_gen_pkg;

    localparam int unsigned NUM_OF_GRADUATE   = 2;
    localparam int unsigned VADDR_WIDTH       = 32;
    localparam int unsigned DEFAULT_ROB_DEPTH = 32;
    localparam int unsigned RESOLVE_TAG_WIDTH = $clog2(DEFAULT_ROB_DEPTH);
    localparam int unsigned COUNT_WIDTH       = 32;

    typedef enum logic {
        SLOT_EMPTY    = 1'b0,
        SLOT_RESOLVED = 1'b1
    } slot_state_e;

    typedef struct packed {
        logic                   valid;
        logic [VADDR_WIDTH-1:0] op_addr;
        logic                   taken;
    } is_taken_feedback_to_pred_t;

    typedef struct packed {
        logic                         valid;
        logic [RESOLVE_TAG_WIDTH-1:0] rob_tag;
        logic [VADDR_WIDTH-1:0]       op_addr;
        logic                         taken;
        logic                         pred;
    } branch_resolve_t;

    typedef struct packed {
        logic                         valid;
        logic [RESOLVE_TAG_WIDTH-1:0] rob_tag;
        logic                         is_branch;
    } graduate_info_t;

    // Outcome source seen by one graduation slot (table hit or same-cycle bypass).
    typedef struct packed {
        logic                   hit;
        logic [VADDR_WIDTH-1:0] op_addr;
        logic                   taken;
        logic                   pred;
    } resolve_src_t;

endpackage

// File: rtl/branch_resolve_table.sv
// Tag-indexed store of resolved branch outcomes with resolve->graduate bypass,
// clear-on-graduate and flash clear on flush.
module branch_resolve_table
    import branch_feedback_gen_pkg::*;
#(
    parameter int unsigned NUM_OF_RESOLVE = 2,
    parameter int unsigned ROB_DEPTH      = DEFAULT_ROB_DEPTH,
    parameter int unsigned ROB_TAG_WIDTH  = $clog2(ROB_DEPTH)
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  branch_resolve_t [NUM_OF_RESOLVE-1:0]            resolve_i,
    input  logic                                            flush,
    input  logic [NUM_OF_GRADUATE-1:0]                      rd_en,
    input  logic [NUM_OF_GRADUATE-1:0][ROB_TAG_WIDTH-1:0]   rd_tag,
    output resolve_src_t [NUM_OF_GRADUATE-1:0]              rd_src_c
);

    slot_state_e            state_q [ROB_DEPTH];
    slot_state_e            state_d [ROB_DEPTH];
    logic [VADDR_WIDTH-1:0] addr_q  [ROB_DEPTH];
    logic [VADDR_WIDTH-1:0] addr_d  [ROB_DEPTH];
    logic                   taken_q [ROB_DEPTH];
    logic                   taken_d [ROB_DEPTH];
    logic                   pred_q  [ROB_DEPTH];
    logic                   pred_d  [ROB_DEPTH];

    // Read path: table contents, overridden by any same-cycle resolve (highest port last).
    always_comb begin
        rd_src_c = '0;
        for (int unsigned g = 0; g < NUM_OF_GRADUATE; g++) begin
            if (state_q[rd_tag[g]] == SLOT_RESOLVED) begin
                rd_src_c[g] = '{hit: 1'b1, op_addr: addr_q[rd_tag[g]],
                                taken: taken_q[rd_tag[g]], pred: pred_q[rd_tag[g]]};
            end
            for (int unsigned r = 0; r < NUM_OF_RESOLVE; r++) begin
                if (resolve_i[r].valid &&
                    (ROB_TAG_WIDTH'(resolve_i[r].rob_tag) == rd_tag[g])) begin
                    rd_src_c[g] = '{hit: 1'b1, op_addr: resolve_i[r].op_addr,
                                    taken: resolve_i[r].taken, pred: resolve_i[r].pred};
                end
            end
        end
    end

    // Write path: resolves first, graduation clears win over them, flush clears all.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        taken_d = taken_q;
        pred_d  = pred_q;
        for (int unsigned r = 0; r < NUM_OF_RESOLVE; r++) begin
            if (resolve_i[r].valid) begin
                state_d[ROB_TAG_WIDTH'(resolve_i[r].rob_tag)] = SLOT_RESOLVED;
                addr_d[ROB_TAG_WIDTH'(resolve_i[r].rob_tag)]  = resolve_i[r].op_addr;
                taken_d[ROB_TAG_WIDTH'(resolve_i[r].rob_tag)] = resolve_i[r].taken;
                pred_d[ROB_TAG_WIDTH'(resolve_i[r].rob_tag)]  = resolve_i[r].pred;
            end
        end
        for (int unsigned g = 0; g < NUM_OF_GRADUATE; g++) begin
            if (rd_en[g]) begin
                state_d[rd_tag[g]] = SLOT_EMPTY;
            end
        end
        if (flush) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                state_d[i] = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
                state_q[i] <= SLOT_EMPTY;
                addr_q[i]  <= '0;
                taken_q[i] <= 1'b0;
                pred_q[i]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            taken_q <= taken_d;
            pred_q  <= pred_d;
        end
    end

endmodule

// File: rtl/branch_feedback_gen.sv
// Predictor feedback producer: releases resolved branch outcomes in graduation
// order and keeps branch / misprediction performance counters.
module branch_feedback_gen
    import branch_feedback_gen_pkg::*;
#(
    parameter int unsigned NUM_OF_RESOLVE = 2,
    parameter int unsigned ROB_DEPTH      = DEFAULT_ROB_DEPTH,
    parameter int unsigned ROB_TAG_WIDTH  = $clog2(ROB_DEPTH)
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [NUM_OF_RESOLVE-1:0]                       resolve_valid,
    input  logic [NUM_OF_RESOLVE-1:0][ROB_TAG_WIDTH-1:0]    resolve_tag,
    input  logic [NUM_OF_RESOLVE-1:0][VADDR_WIDTH-1:0]      resolve_addr,
    input  logic [NUM_OF_RESOLVE-1:0]                       resolve_taken,
    input  logic [NUM_OF_RESOLVE-1:0]                       resolve_pred,
    input  logic [NUM_OF_GRADUATE-1:0]                      grad_valid,
    input  logic [NUM_OF_GRADUATE-1:0][ROB_TAG_WIDTH-1:0]   grad_tag,
    input  logic [NUM_OF_GRADUATE-1:0]                      grad_is_branch,
    input  logic                                            flush_in,
    output is_taken_feedback_to_pred_t [NUM_OF_GRADUATE-1:0] feedback,
    output logic [COUNT_WIDTH-1:0]                          branch_count,
    output logic [COUNT_WIDTH-1:0]                          mispred_count,
    output logic                                            missing_resolve
);

    branch_resolve_t [NUM_OF_RESOLVE-1:0]   resolve_c;
    logic [NUM_OF_GRADUATE-1:0]             grad_en_c;
    resolve_src_t [NUM_OF_GRADUATE-1:0]     src_c;

    is_taken_feedback_to_pred_t [NUM_OF_GRADUATE-1:0] feedback_q, feedback_d;
    logic [COUNT_WIDTH-1:0] branch_count_q, branch_count_d;
    logic [COUNT_WIDTH-1:0] mispred_count_q, mispred_count_d;
    logic                   missing_resolve_q, missing_resolve_d;

    always_comb begin
        for (int unsigned r = 0; r < NUM_OF_RESOLVE; r++) begin
            resolve_c[r] = '{valid:   resolve_valid[r],
                             rob_tag: RESOLVE_TAG_WIDTH'(resolve_tag[r]),
                             op_addr: resolve_addr[r],
                             taken:   resolve_taken[r],
                             pred:    resolve_pred[r]};
        end
    end

    assign grad_en_c = grad_valid & grad_is_branch;

    branch_resolve_table #(
        .NUM_OF_RESOLVE (NUM_OF_RESOLVE),
        .ROB_DEPTH      (ROB_DEPTH),
        .ROB_TAG_WIDTH  (ROB_TAG_WIDTH)
    ) u_table (
        .clock     (clock),
        .reset     (reset),
        .resolve_i (resolve_c),
        .flush     (flush_in),
        .rd_en     (grad_en_c),
        .rd_tag    (grad_tag),
        .rd_src_c  (src_c)
    );

    // A graduating branch without any outcome source is a sticky protocol error.
    always_comb begin
        feedback_d        = '0;
        branch_count_d    = branch_count_q;
        mispred_count_d   = mispred_count_q;
        missing_resolve_d = missing_resolve_q;
        for (int unsigned g = 0; g < NUM_OF_GRADUATE; g++) begin
            if (grad_en_c[g]) begin
                if (src_c[g].hit) begin
                    feedback_d[g].valid   = 1'b1;
                    feedback_d[g].op_addr = src_c[g].op_addr;
                    feedback_d[g].taken   = src_c[g].taken;
                    branch_count_d        = branch_count_d + COUNT_WIDTH'(1);
                    if (src_c[g].pred != src_c[g].taken) begin
                        mispred_count_d = mispred_count_d + COUNT_WIDTH'(1);
                    end
                end else begin
                    missing_resolve_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            feedback_q        <= '0;
            branch_count_q    <= '0;
            mispred_count_q   <= '0;
            missing_resolve_q <= 1'b0;
        end else begin
            feedback_q        <= feedback_d;
            branch_count_q    <= branch_count_d;
            mispred_count_q   <= mispred_count_d;
            missing_resolve_q <= missing_resolve_d;
        end
    end

    assign feedback        = feedback_q;
    assign branch_count    = branch_count_q;
    assign mispred_count   = mispred_count_q;
    assign missing_resolve = missing_resolve_q;

endmodule

// File: tb/tb_branch_feedback_gen.sv
// Directed bench for branch_feedback_gen: hand-computed feedback, counters and error flag.
module tb_branch_feedback_gen;
    import branch_feedback_gen_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic [1:0]       resolve_valid;
    logic [1:0][4:0]  resolve_tag;
    logic [1:0][31:0] resolve_addr;
    logic [1:0]       resolve_taken;
    logic [1:0]       resolve_pred;
    logic [1:0]       grad_valid;
    logic [1:0][4:0]  grad_tag;
    logic [1:0]       grad_is_branch;
    logic             flush_in;
    is_taken_feedback_to_pred_t [1:0] feedback;
    logic [31:0]      branch_count;
    logic [31:0]      mispred_count;
    logic             missing_resolve;

    int compared   = 0;
    int mismatched = 0;

    branch_feedback_gen dut (
        .clock           (clock),
        .reset           (reset),
        .resolve_valid   (resolve_valid),
        .resolve_tag     (resolve_tag),
        .resolve_addr    (resolve_addr),
        .resolve_taken   (resolve_taken),
        .resolve_pred    (resolve_pred),
        .grad_valid      (grad_valid),
        .grad_tag        (grad_tag),
        .grad_is_branch  (grad_is_branch),
        .flush_in        (flush_in),
        .feedback        (feedback),
        .branch_count    (branch_count),
        .mispred_count   (mispred_count),
        .missing_resolve (missing_resolve)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_fb(input string name, input logic s, input logic v,
                          input logic [31:0] a, input logic t);
        chk({name, ".valid"},   32'(feedback[s].valid), 32'(v));
        chk({name, ".op_addr"}, feedback[s].op_addr,    a);
        chk({name, ".taken"},   32'(feedback[s].taken), 32'(t));
    endtask

    task automatic chk_cnt(input string name, input logic [31:0] bc, input logic [31:0] mc,
                           input logic miss);
        chk({name, ".branch_count"},    branch_count,             bc);
        chk({name, ".mispred_count"},   mispred_count,            mc);
        chk({name, ".missing_resolve"}, 32'(missing_resolve),     32'(miss));
    endtask

    task automatic idle();
        resolve_valid  = '0;
        resolve_tag    = '0;
        resolve_addr   = '0;
        resolve_taken  = '0;
        resolve_pred   = '0;
        grad_valid     = '0;
        grad_tag       = '0;
        grad_is_branch = '0;
        flush_in       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_resolve(input logic p, input logic [4:0] tag, input logic [31:0] addr,
                               input logic tk, input logic pr);
        resolve_valid[p] = 1'b1;
        resolve_tag[p]   = tag;
        resolve_addr[p]  = addr;
        resolve_taken[p] = tk;
        resolve_pred[p]  = pr;
    endtask

    task automatic set_grad(input logic s, input logic [4:0] tag, input logic br);
        grad_valid[s]     = 1'b1;
        grad_tag[s]       = tag;
        grad_is_branch[s] = br;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_fb("reset_s0", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_fb("reset_s1", 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt("reset", 32'd0, 32'd0, 1'b0);

        // Basic: resolve, wait, graduate.
        set_resolve(1'b0, 5'd5, 32'h1000, 1'b1, 1'b1);
        tick(); idle();
        repeat (3) tick();
        set_grad(1'b0, 5'd5, 1'b1);
        tick(); idle();
        chk_fb("basic", 1'b0, 1'b1, 32'h1000, 1'b1);
        chk_fb("basic_s1", 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt("basic", 32'd1, 32'd0, 1'b0);
        tick();
        chk_fb("basic_drop", 1'b0, 1'b0, 32'h0, 1'b0);

        // Out-of-order resolve, dual graduate.
        set_resolve(1'b0, 5'd9, 32'h2004, 1'b0, 1'b1);
        tick(); idle();
        set_resolve(1'b0, 5'd8, 32'h2000, 1'b1, 1'b1);
        tick(); idle();
        set_grad(1'b0, 5'd8, 1'b1);
        set_grad(1'b1, 5'd9, 1'b1);
        tick(); idle();
        chk_fb("ooo_s0", 1'b0, 1'b1, 32'h2000, 1'b1);
        chk_fb("ooo_s1", 1'b1, 1'b1, 32'h2004, 1'b0);
        chk_cnt("ooo", 32'd3, 32'd1, 1'b0);

        // Same-cycle bypass.
        set_resolve(1'b0, 5'd3, 32'h3000, 1'b1, 1'b1);
        set_grad(1'b0, 5'd3, 1'b1);
        tick(); idle();
        chk_fb("bypass", 1'b0, 1'b1, 32'h3000, 1'b1);
        chk_cnt("bypass", 32'd4, 32'd1, 1'b0);

        // Bypass with two ports on one tag: higher port wins.
        set_resolve(1'b0, 5'd11, 32'h4000, 1'b0, 1'b0);
        set_resolve(1'b1, 5'd11, 32'h4400, 1'b1, 1'b0);
        set_grad(1'b1, 5'd11, 1'b1);
        tick(); idle();
        chk_fb("byp_prio_s0", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_fb("byp_prio_s1", 1'b1, 1'b1, 32'h4400, 1'b1);
        chk_cnt("byp_prio", 32'd5, 32'd2, 1'b0);

        // Table write with two ports on one tag: higher port wins.
        set_resolve(1'b0, 5'd12, 32'h5000, 1'b1, 1'b1);
        set_resolve(1'b1, 5'd12, 32'h5500, 1'b0, 1'b0);
        tick(); idle();
        set_grad(1'b0, 5'd12, 1'b1);
        tick(); idle();
        chk_fb("dup_tag", 1'b0, 1'b1, 32'h5500, 1'b0);
        chk_cnt("dup_tag", 32'd6, 32'd2, 1'b0);

        // Re-resolve overwrites.
        set_resolve(1'b0, 5'd13, 32'h6000, 1'b1, 1'b1);
        tick(); idle();
        set_resolve(1'b1, 5'd13, 32'h6600, 1'b0, 1'b1);
        tick(); idle();
        set_grad(1'b0, 5'd13, 1'b1);
        tick(); idle();
        chk_fb("overwrite", 1'b0, 1'b1, 32'h6600, 1'b0);
        chk_cnt("overwrite", 32'd7, 32'd3, 1'b0);

        // Non-branch graduation.
        set_grad(1'b0, 5'd7, 1'b0);
        tick(); idle();
        chk_fb("nonbranch", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt("nonbranch", 32'd7, 32'd3, 1'b0);

        // Unresolved tag, plus previously graduated slots are now empty.
        set_grad(1'b0, 5'd10, 1'b1);
        set_grad(1'b1, 5'd5, 1'b1);
        tick(); idle();
        chk_fb("missing_s0", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_fb("slot5_empty", 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt("missing", 32'd7, 32'd3, 1'b1);
        set_grad(1'b0, 5'd3, 1'b1);
        set_grad(1'b1, 5'd8, 1'b1);
        tick(); idle();
        chk_fb("slot3_empty", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_fb("slot8_empty", 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) tick();
        chk_cnt("missing_sticky", 32'd7, 32'd3, 1'b1);

        // Asynchronous reset mid-cycle after a graduation.
        set_resolve(1'b0, 5'd20, 32'h8000, 1'b1, 1'b1);
        set_resolve(1'b1, 5'd21, 32'h8100, 1'b0, 1'b0);
        tick(); idle();
        set_grad(1'b0, 5'd20, 1'b1);
        tick(); idle();
        chk_fb("pre_rst", 1'b0, 1'b1, 32'h8000, 1'b1);
        chk_cnt("pre_rst", 32'd8, 32'd3, 1'b1);
        set_grad(1'b0, 5'd21, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk_fb("async_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt("async_rst", 32'd0, 32'd0, 1'b0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        chk_fb("post_rst", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt("post_rst", 32'd0, 32'd0, 1'b0);
        set_grad(1'b0, 5'd21, 1'b1);
        tick(); idle();
        chk_fb("slot21_cleared", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt("slot21_cleared", 32'd0, 32'd0, 1'b1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_cnt("reset2", 32'd0, 32'd0, 1'b0);

        // Flush: graduation in the flush cycle survives, everything else is dropped.
        set_resolve(1'b0, 5'd1, 32'h7000, 1'b1, 1'b0);
        set_resolve(1'b1, 5'd2, 32'h7100, 1'b0, 1'b0);
        tick(); idle();
        set_resolve(1'b0, 5'd4, 32'h7200, 1'b1, 1'b1);
        tick(); idle();
        flush_in = 1'b1;
        set_grad(1'b0, 5'd1, 1'b1);
        set_resolve(1'b0, 5'd6, 32'h7300, 1'b1, 1'b1);
        tick(); idle();
        chk_fb("flush_grad", 1'b0, 1'b1, 32'h7000, 1'b1);
        chk_fb("flush_s1", 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt("flush_grad", 32'd1, 32'd1, 1'b0);
        set_grad(1'b0, 5'd2, 1'b1);
        set_grad(1'b1, 5'd4, 1'b1);
        tick(); idle();
        chk_fb("flushed_tag2", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_fb("flushed_tag4", 1'b1, 1'b0, 32'h0, 1'b0);
        chk_cnt("flushed", 32'd1, 32'd1, 1'b1);
        set_grad(1'b0, 5'd6, 1'b1);
        tick(); idle();
        chk_fb("dropped_tag6", 1'b0, 1'b0, 32'h0, 1'b0);
        chk_cnt("dropped_tag6", 32'd1, 32'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
